regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file for the datapath: `2**ADDR_WIDTH` registers of `DATA_WIDTH` bits, one synchronous write port, two independent combinational read ports (A and B) and a per-register busy scoreboard for tracking in-flight results. It replaces the fixed 8x16 single-read-port register file. The ALU operand paths feed from ports A and B, and the writeback stage drives the write port.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per register
- ADDR_WIDTH, 3, register index width; depth = 2**ADDR_WIDTH
- ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes and marks

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- data_in  in  DATA_WIDTH  write data
- writenum  in  ADDR_WIDTH  write index
- write  in  1  write enable
- readnum_a  in  ADDR_WIDTH  read index, port A
- readnum_b  in  ADDR_WIDTH  read index, port B
- data_out_a  out  DATA_WIDTH  read data, port A
- data_out_b  out  DATA_WIDTH  read data, port B
- mark  in  1  set busy bit of marknum
- marknum  in  ADDR_WIDTH  index to mark busy
- busy_a  out  1  busy bit of readnum_a
- busy_b  out  1  busy bit of readnum_b

## Operation
- Storage: `R[0..2**ADDR_WIDTH-1]`, each DATA_WIDTH bits, plus `busy[0..2**ADDR_WIDTH-1]`.
- Reset: at a rising edge with reset=1, all R clear to 0 and all busy bits clear to 0. Reset overrides write and mark in that cycle.
- Write: at a rising edge with write=1 (reset=0), `R[writenum] <= data_in` and `busy[writenum] <= 0`.
- Mark: at a rising edge with mark=1 (reset=0), `busy[marknum] <= 1`.
- Write and mark to the same index in the same cycle: the data is stored and busy ends at 1, so mark wins.
- Write and mark to different indices: both take effect.
- Reads: data_out_x = R[readnum_x] and busy_x = busy[readnum_x], both combinational. Both ports may address the same register.
- ZERO_REG=1: index 0 returns 0 data and busy=0. Writes and marks to index 0 are discarded.
- No width conversion: data_in is stored verbatim. Indices are always in range by construction.

## Timing
- Write latency: 1 edge. Without bypass, new data is visible on data_out_x from the cycle after the write edge.
- Busy set latency: 1 edge after mark. Busy clear latency: 1 edge after write.
- Reset values: data_out_a = data_out_b = 0 and busy_a = busy_b = 0 from the first cycle after the reset edge. Before the first reset the contents are undefined.
- Reset mid-operation: any write or mark presented with reset=1 is lost. Reads during the reset cycle show the pre-reset contents.
- No handshake: write and mark are single-cycle strobes and may be held to repeat.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read port whose readnum equals writenum while write=1 and reset=0 returns data_in combinationally, in the same cycle, and reports busy=0. Mark has no bypass.
  - Under ZERO_REG=1, index 0 is never bypassed.
  - Reset=1 suppresses bypass.
- `REGFILE_BYPASS_EN` undefined: reads always return stored state, with no forwarding.

## Test plan
- Reset, then write 42 (0x002A) to R3 with readnum_a=readnum_b=3 -> data_out_a = data_out_b = 0x002A after the edge. Before the edge they are 0x0000 (no bypass) or 0x002A (bypass).
- Write 0xFF98 to R7 and 0x1234 to R2 on consecutive edges, read A=7 and B=2 -> data_out_a = 0xFF98, data_out_b = 0x1234. Then reset -> both 0x0000.
- mark=1, marknum=5, readnum_a=5 -> busy_a = 1 after the edge. Write 0x0055 to R5 -> busy_a = 0 and data_out_a = 0x0055 next cycle. With bypass, busy_a = 0 during the write cycle.
- Same-cycle write 0x00AA and mark to R4 -> data_out = 0x00AA and busy = 1 after the edge.
- ZERO_REG=1: write 0xBEEF to R0 and mark R0 -> data_out_a = 0x0000 and busy_a = 0 in all cycles.
- Write 0x0F0F to R1 with reset=1 in the same cycle -> R1 = 0x0000 after the edge. No bypass of 0x0F0F during that cycle.

Source files
------------

// File: rtl/regfile_mp_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_if
//
// Bundles the write, mark and read traffic of the multi-port register file.
// Clock and reset are not part of the bundle. They stay plain ports on the
// register file itself.
//
// Parameters:
//   DATA_WIDTH  bits per register
//   ADDR_WIDTH  register index width
//
// Signals:
//   data_in     write data                  (master -> slave)
//   writenum    write index                 (master -> slave)
//   write       write strobe                (master -> slave)
//   mark        busy-mark strobe            (master -> slave)
//   marknum     index to mark busy          (master -> slave)
//   readnum_a   read index, port A          (master -> slave)
//   readnum_b   read index, port B          (master -> slave)
//   data_out_a  read data, port A           (slave -> master)
//   data_out_b  read data, port B           (slave -> master)
//   busy_a      busy bit of readnum_a       (slave -> master)
//   busy_b      busy bit of readnum_b       (slave -> master)
//
// Modports:
//   master  the writeback / operand-fetch side that drives indices and data
//   slave   the register file
// ---------------------------------------------------------------------------
interface regfile_mp_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] writenum;
    logic                  write;
    logic                  mark;
    logic [ADDR_WIDTH-1:0] marknum;
    logic [ADDR_WIDTH-1:0] readnum_a;
    logic [ADDR_WIDTH-1:0] readnum_b;
    logic [DATA_WIDTH-1:0] data_out_a;
    logic [DATA_WIDTH-1:0] data_out_b;
    logic                  busy_a;
    logic                  busy_b;

    modport master (
        output data_in,
        output writenum,
        output write,
        output mark,
        output marknum,
        output readnum_a,
        output readnum_b,
        input  data_out_a,
        input  data_out_b,
        input  busy_a,
        input  busy_b
    );

    modport slave (
        input  data_in,
        input  writenum,
        input  write,
        input  mark,
        input  marknum,
        input  readnum_a,
        input  readnum_b,
        output data_out_a,
        output data_out_b,
        output busy_a,
        output busy_b
    );
endinterface

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//
// Parametrised multi-port register file with a per-register busy scoreboard.
// It holds 2**ADDR_WIDTH registers of DATA_WIDTH bits. It has one synchronous
// write port and two independent combinational read ports, A and B. Each
// register has a busy bit that the issue logic sets with "mark" when a result
// is in flight. A write to the register clears that bit. When a write and a
// mark hit the same index in one cycle, the mark wins, so the register is
// left busy.
//
// Parameters:
//   DATA_WIDTH  bits per register (default 16)
//   ADDR_WIDTH  register index width, depth = 2**ADDR_WIDTH (default 3)
//   ZERO_REG    when 1, register 0 reads as 0 / not busy and drops
//               writes and marks (default 0)
//
// Ports:
//   clk    single clock, every state update is on the rising edge
//   reset  synchronous active-high reset. It clears all data and busy bits
//          and takes priority over write and mark.
//   bus    regfile_mp_if.slave, carrying the write, mark and read traffic
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read port whose index matches an
//                      active write returns data_in in the same cycle and
//                      reports not busy. Marks are never forwarded. Reset
//                      and the ZERO_REG index both suppress forwarding.
//                      When the macro is undefined, reads always return
//                      stored state.
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0
) (
    input  logic             clk,
    input  logic             reset,
    regfile_mp_if.slave      bus
);
    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;

    logic                  write_ok;
    logic                  mark_ok;

    logic [DATA_WIDTH-1:0] rd_data_a;
    logic [DATA_WIDTH-1:0] rd_data_b;
    logic                  rd_busy_a;
    logic                  rd_busy_b;

    // A write or mark counts only when reset is low. Under ZERO_REG it must
    // also not target index 0. The write qualifier is reused for the bypass
    // match, so reset and the zero register suppress forwarding for free.
    always_comb begin
        write_ok = bus.write && !reset;
        mark_ok  = bus.mark  && !reset;
        if (ZERO_EN && (bus.writenum == '0)) begin
            write_ok = 1'b0;
        end
        if (ZERO_EN && (bus.marknum == '0)) begin
            mark_ok = 1'b0;
        end
    end

    // Storage and scoreboard update. The mark assignment comes after the
    // write assignment. For a write and a mark to the same index, the
    // busy bit therefore ends at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (write_ok) begin
                regs[bus.writenum] <= bus.data_in;
                busy[bus.writenum] <= 1'b0;
            end
            if (mark_ok) begin
                busy[bus.marknum] <= 1'b1;
            end
        end
    end

    // Read port A: the stored value, or forwarded write data when bypass is
    // built in. Index 0 is forced to zero under ZERO_REG. This also covers
    // the time before the first reset, while the storage is still undefined.
    always_comb begin
        rd_data_a = regs[bus.readnum_a];
        rd_busy_a = busy[bus.readnum_a];
        if (ZERO_EN && (bus.readnum_a == '0)) begin
            rd_data_a = '0;
            rd_busy_a = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (write_ok && (bus.readnum_a == bus.writenum)) begin
            rd_data_a = bus.data_in;
            rd_busy_a = 1'b0;
        end
`else
`endif
    end

    // Read port B works the same way as port A and is fully independent of
    // it. Both ports may address the same register.
    always_comb begin
        rd_data_b = regs[bus.readnum_b];
        rd_busy_b = busy[bus.readnum_b];
        if (ZERO_EN && (bus.readnum_b == '0)) begin
            rd_data_b = '0;
            rd_busy_b = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (write_ok && (bus.readnum_b == bus.writenum)) begin
            rd_data_b = bus.data_in;
            rd_busy_b = 1'b0;
        end
`else
`endif
    end

    assign bus.data_out_a = rd_data_a;
    assign bus.data_out_b = rd_data_b;
    assign bus.busy_a     = rd_busy_a;
    assign bus.busy_b     = rd_busy_b;

endmodule
